debug_exec_ctrl: RTL and testbench

- Execution controller between the debug command interface and the CPU's halt input.
- Accepts debug commands: run, step-instruction, step-cycles, set/clear breakpoint, halt.
- Sequences cpu_halt from the CPU's instruction-retired flag and fetch-address breakpoint matches.
- Reports each command's completion with a one-cycle pulse; sits in the debug harness between host command decode and the CPU top.

---
 rtl/debug_pkg.sv | 29 ++
 rtl/debug_bp_match.sv | 46 ++++
 rtl/debug_exec_ctrl.sv | 160 ++++++++++++++++
 tb/tb_debug_exec_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared opcode and execution-state encodings for the debug harness.
// The host command decoder reuses these constants.
package debug_pkg;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_RUN   = 4'd1,
    CMD_STEPI = 4'd2,
    CMD_STEPC = 4'd3,
    CMD_SETBP = 4'd4,
    CMD_CLRBP = 4'd5,
    CMD_HALT  = 4'd6
  } debug_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEPI = 3'd2,
    ST_STEPC = 3'd3,
    ST_DONE  = 3'd4
  } exec_state_e;

  localparam logic [3:0] CMD_LAST_LEGAL = 4'd6;

  function automatic logic is_legal_cmd(input logic [3:0] op);
    return op <= CMD_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/debug_bp_match.sv
// Hardware breakpoint slots: address/enable registers compared in parallel
// against the fetch address; the lowest matching slot wins.
module debug_bp_match #(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 32,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              match,
  output logic [IDX_W-1:0]  match_idx
);

  logic [ADDR_W-1:0] bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bp_en <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else if (set_en) begin
      bp_en[wr_idx]   <= 1'b1;
      bp_addr[wr_idx] <= wr_addr;
    end else if (clr_en) begin
      bp_en[wr_idx] <= 1'b0;
    end
  end

  // Scan from the top so the lowest matching slot is the last one written.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i] == pc)) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/debug_exec_ctrl.sv
// Debug execution controller: sequences cpu_halt for run/step commands and
// breakpoints. Optional retire counter port enabled by DEBUG_RETIRE_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE  0  | CPU halted, waiting for a host command
// RUN   1  | CPU free-running until breakpoint match or HALT
// STEPI 2  | CPU running until the next retired instruction
// STEPC 3  | CPU running for a fixed number of cycles
// DONE  4  | CPU halted, completion pulse for the accepted command
module debug_exec_ctrl
  import debug_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 32,
  parameter int CYC_W  = 16,
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        debug_cmd,
  input  logic [IDX_W-1:0]  cmd_idx,
  input  logic [ADDR_W-1:0] cmd_arg,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instr_retired,
  output logic              cpu_halt,
  output logic              command_complete,
  output logic              cmd_err,
  output logic              bp_hit,
  output logic [IDX_W-1:0]  bp_index,
  output logic [2:0]        ctrl_state
`ifdef DEBUG_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  exec_state_e      state;
  logic [CYC_W-1:0] cyc_cnt;
  logic             first_run;
  logic             accept;
  logic             idle_accept;
  logic             bp_match_raw;
  logic [IDX_W-1:0] bp_match_idx;
  logic             bp_stop;

  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE:                     cmd_ready = 1'b1;
      ST_RUN, ST_STEPI, ST_STEPC:  cmd_ready = (debug_cmd == CMD_HALT);
      default:                     cmd_ready = 1'b0;
    endcase
  end

  assign accept      = cmd_valid && cmd_ready;
  assign idle_accept = accept && (state == ST_IDLE);

  // Suppressing the first RUN cycle lets a resume from a breakpoint address make progress.
  assign bp_stop    = (state == ST_RUN) && !first_run && bp_match_raw;
  assign cpu_halt   = !(((state == ST_RUN) && !bp_stop) || (state == ST_STEPI) || (state == ST_STEPC));
  assign ctrl_state = state;

  debug_bp_match #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W)
  ) u_bp_match (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en    (idle_accept && (debug_cmd == CMD_SETBP)),
    .clr_en    (idle_accept && (debug_cmd == CMD_CLRBP)),
    .wr_idx    (cmd_idx),
    .wr_addr   (cmd_arg),
    .pc        (pc),
    .match     (bp_match_raw),
    .match_idx (bp_match_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cyc_cnt          <= '0;
      first_run        <= 1'b0;
      command_complete <= 1'b0;
      cmd_err          <= 1'b0;
      bp_hit           <= 1'b0;
      bp_index         <= '0;
    end else begin
      command_complete <= 1'b0;
      cmd_err          <= 1'b0;
      first_run        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (!is_legal_cmd(debug_cmd)) begin
              state            <= ST_DONE;
              command_complete <= 1'b1;
              cmd_err          <= 1'b1;
            end else if (debug_cmd == CMD_RUN) begin
              state     <= ST_RUN;
              bp_hit    <= 1'b0;
              first_run <= 1'b1;
            end else if (debug_cmd == CMD_STEPI) begin
              state <= ST_STEPI;
            end else if (debug_cmd == CMD_STEPC) begin
              state   <= ST_STEPC;
              cyc_cnt <= (cmd_arg[CYC_W-1:0] == '0) ? CYC_W'(1) : cmd_arg[CYC_W-1:0];
            end else begin
              state            <= ST_DONE;
              command_complete <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            state            <= ST_DONE;
            command_complete <= 1'b1;
          end else if (bp_stop) begin
            state            <= ST_DONE;
            command_complete <= 1'b1;
            bp_hit           <= 1'b1;
            bp_index         <= bp_match_idx;
          end
        end
        ST_STEPI: begin
          if (accept || instr_retired) begin
            state            <= ST_DONE;
            command_complete <= 1'b1;
          end
        end
        ST_STEPC: begin
          cyc_cnt <= cyc_cnt - CYC_W'(1);
          if (accept || (cyc_cnt == CYC_W'(1))) begin
            state            <= ST_DONE;
            command_complete <= 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef DEBUG_RETIRE_CNT_EN
  // A retire landing on the clearing cycle is counted as the first one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if (idle_accept && cmd_arg[31] &&
                 ((debug_cmd == CMD_RUN) || (debug_cmd == CMD_STEPI))) begin
      retire_count <= 32'(instr_retired);
    end else if (instr_retired) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_debug_exec_ctrl.sv
// Scoreboard bench for debug_exec_ctrl: random commands against a
// behavioural model of breakpoints, step lengths and stop reasons.
module tb_debug_exec_ctrl;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_RUN   = 4'd1;
  localparam logic [3:0] OP_STEPI = 4'd2;
  localparam logic [3:0] OP_STEPC = 4'd3;
  localparam logic [3:0] OP_SETBP = 4'd4;
  localparam logic [3:0] OP_CLRBP = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd6;
  localparam int LIMIT = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  debug_cmd;
  logic [1:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        instr_retired;
  logic        cpu_halt;
  logic        command_complete;
  logic        cmd_err;
  logic        bp_hit;
  logic [1:0]  bp_index;
  logic [2:0]  ctrl_state;

  always #5 clk = ~clk;

  debug_exec_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .debug_cmd        (debug_cmd),
    .cmd_idx          (cmd_idx),
    .cmd_arg          (cmd_arg),
    .pc               (pc),
    .instr_retired    (instr_retired),
    .cpu_halt         (cpu_halt),
    .command_complete (command_complete),
    .cmd_err          (cmd_err),
    .bp_hit           (bp_hit),
    .bp_index         (bp_index),
    .ctrl_state       (ctrl_state)
  );

  typedef struct {
    logic       err;
    logic       hit;
    logic [1:0] idx;
    int         low;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   ncomplete = 0;
  int   low_cnt = 0;
  bit   post = 1'b0;

  logic        m_en [4];
  logic [31:0] m_addr [4];
  logic        m_hit;
  logic [1:0]  m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i]   = 1'b0;
      m_addr[i] = 32'h0;
    end
    m_hit = 1'b0;
    m_idx = 2'd0;
  endtask

  task automatic push(input logic err, input int low);
    exp_t e;
    e.err = err;
    e.hit = m_hit;
    e.idx = m_idx;
    e.low = low;
    sb.push_back(e);
  endtask

  // Monitor: counts CPU run cycles and checks each completion against the queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      low_cnt = 0;
      post    = 1'b0;
    end else begin
      if (post) begin
        chk("pulse_width", {31'd0, command_complete}, 32'd0);
        chk("back_to_idle", {29'd0, ctrl_state}, 32'd0);
        post = 1'b0;
      end
      if (command_complete) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_complete: got completion, want none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cmd_err", {31'd0, cmd_err}, {31'd0, e.err});
          chk("bp_hit", {31'd0, bp_hit}, {31'd0, e.hit});
          if (e.hit) chk("bp_index", {30'd0, bp_index}, {30'd0, e.idx});
          chk("run_cycles", 32'(low_cnt), 32'(e.low));
          chk("done_state", {29'd0, ctrl_state}, 32'd4);
        end
        low_cnt = 0;
        ncomplete++;
        post = 1'b1;
      end else if (!cpu_halt) begin
        low_cnt++;
      end
    end
  end

  task automatic wait_done();
    int start;
    start = ncomplete;
    for (int c = 0; c < 300 && ncomplete == start; c++) @(posedge clk);
    if (ncomplete == start) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no completion, want one within 300 cycles");
    end
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] idx, input logic [31:0] arg);
    cmd_valid = 1'b1;
    debug_cmd = op;
    cmd_idx   = idx;
    cmd_arg   = arg;
    #1;
    chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    debug_cmd = OP_NOP;
  endtask

  task automatic do_simple(input logic [3:0] op, input logic [1:0] idx, input logic [31:0] arg);
    logic err;
    err = (op > 4'd6);
    if (op == OP_SETBP) begin
      m_en[idx]   = 1'b1;
      m_addr[idx] = arg;
    end else if (op == OP_CLRBP) begin
      m_en[idx] = 1'b0;
    end
    push(err, 0);
    issue(op, idx, arg);
    wait_done();
  endtask

  task automatic do_stepc(input int n);
    push(1'b0, (n == 0) ? 1 : n);
    issue(OP_STEPC, 2'd0, {16'($urandom), 16'(n)});
    wait_done();
  endtask

  task automatic do_stepi(input int k);
    push(1'b0, k + 1);
    issue(OP_STEPI, 2'd0, $urandom);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    instr_retired = 1'b1;
    @(posedge clk);
    #1;
    instr_retired = 1'b0;
    wait_done();
  endtask

  // The CPU model fetches start, start+4, ... one address per RUN cycle.
  task automatic do_run(input logic [31:0] start, input bit halt_mode);
    int jm, hj, last, low;
    logic [1:0] hidx;
    jm = 0;
    hidx = 2'd0;
    for (int j = 2; j <= LIMIT; j++)
      for (int i = 0; i < 4; i++)
        if (jm == 0 && m_en[i] && m_addr[i] == start + 32'(4 * (j - 1))) begin
          jm = j;
          hidx = 2'(i);
        end
    m_hit = 1'b0;
    if (jm != 0 && !halt_mode) begin
      m_hit = 1'b1;
      m_idx = hidx;
      hj = 0;
      last = jm;
      low = jm - 1;
    end else if (jm != 0) begin
      hj = jm;
      last = jm;
      low = jm - 1;
    end else begin
      hj = LIMIT;
      last = LIMIT;
      low = LIMIT;
    end
    push(1'b0, low);
    issue(OP_RUN, 2'd0, $urandom);
    pc = start;
    chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
    for (int j = 2; j <= last; j++) begin
      @(posedge clk);
      #1;
      pc = start + 32'(4 * (j - 1));
      if (j == hj) begin
        cmd_valid = 1'b1;
        debug_cmd = OP_HALT;
        #1;
        chk("ready_halt", {31'd0, cmd_ready}, 32'd1);
      end
    end
    if (hj != 0) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      debug_cmd = OP_NOP;
    end
    wait_done();
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    debug_cmd = OP_NOP;
    cmd_idx = 2'd0;
    cmd_arg = 32'h0;
    pc = 32'h0;
    instr_retired = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_halt", {31'd0, cpu_halt}, 32'd1);
    chk("rst_complete", {31'd0, command_complete}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst_bp_index", {30'd0, bp_index}, 32'd0);
    chk("rst_state", {29'd0, ctrl_state}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_stepc(5);
    do_simple(OP_SETBP, 2'd1, 32'h10);
    do_run(32'h0, 1'b0);
    do_run(32'h10, 1'b0);
    do_stepi(3);
    do_run(32'h0, 1'b1);
    do_simple(4'hF, 2'd0, 32'h0);
    do_stepc(0);

    // Reset in the middle of a long STEPC aborts it silently and clears breakpoints.
    issue(OP_STEPC, 2'd0, 32'd50);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("stepc_running", {31'd0, cpu_halt}, 32'd0);
    sb.delete();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_cpu_halt", {31'd0, cpu_halt}, 32'd1);
    chk("midrst_state", {29'd0, ctrl_state}, 32'd0);
    chk("midrst_complete", {31'd0, command_complete}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_run(32'h0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: do_simple(OP_SETBP, 2'($urandom_range(0, 3)), 32'(4 * $urandom_range(0, 16)));
        2:    do_simple(OP_CLRBP, 2'($urandom_range(0, 3)), $urandom);
        3:    do_simple(($urandom_range(0, 1) != 0) ? OP_HALT : OP_NOP, 2'd0, $urandom);
        4:    do_simple(4'($urandom_range(7, 15)), 2'd0, $urandom);
        5:    do_stepc($urandom_range(0, 12));
        6:    do_stepi($urandom_range(0, 6));
        default: do_run(32'(4 * $urandom_range(0, 16)), $urandom_range(0, 3) == 0);
      endcase
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
